// File: rtl/alu.sv
// Single-cycle integer execution unit: decodes RV32 OP/OP-IMM/LW/SW and returns a
// registered result tagged with the destination physical register.
module alu #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  input  logic [PREG_W-1:0] dest_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   result,
  output logic [PREG_W-1:0] dest_o,
  output logic              illegal_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [XLEN-1:0] alu_res;
  logic            illegal;
  logic [4:0]      shamt;
  logic [XLEN-1:0] add_res;
  logic [XLEN-1:0] sub_res;
  logic [XLEN-1:0] slt_res;
  logic [XLEN-1:0] sltu_res;
  logic [XLEN-1:0] sll_res;
  logic [XLEN-1:0] srl_res;
  logic [XLEN-1:0] sra_res;

  assign shamt    = src2[4:0];
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
  assign sltu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
  assign sll_res  = src1 << shamt;
  assign srl_res  = src1 >> shamt;
  assign sra_res  = $signed(src1) >>> shamt;

  // Illegal paths leave alu_res at zero so the output register clears the result.
  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        case (func3)
          3'b000: alu_res = add_res;
          3'b111: alu_res = src1 & src2;
          3'b110: alu_res = src1 | src2;
          3'b100: alu_res = src1 ^ src2;
          3'b010: alu_res = slt_res;
          3'b011: alu_res = sltu_res;
          3'b001: begin
            if (func7 == F7_BASE) alu_res = sll_res;
            else                  illegal = 1'b1;
          end
          default: begin
            if (func7 == F7_BASE)     alu_res = srl_res;
            else if (func7 == F7_ALT) alu_res = sra_res;
            else                      illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        case (func3)
          3'b000: begin
            if (func7 == F7_BASE)     alu_res = add_res;
            else if (func7 == F7_ALT) alu_res = sub_res;
            else                      illegal = 1'b1;
          end
          3'b100: alu_res = src1 ^ src2;
          3'b110: alu_res = src1 | src2;
          3'b111: alu_res = src1 & src2;
          3'b010: alu_res = slt_res;
          3'b011: alu_res = sltu_res;
          3'b001: begin
            if (func7 == F7_BASE) alu_res = sll_res;
            else                  illegal = 1'b1;
          end
          default: begin
            if (func7 == F7_BASE)     alu_res = srl_res;
            else if (func7 == F7_ALT) alu_res = sra_res;
            else                      illegal = 1'b1;
          end
        endcase
      end
      OPC_LOAD, OPC_STORE: alu_res = add_res;
      default:             illegal = 1'b1;
    endcase
  end

  // result and dest_o only update on an issued op; idle cycles hold them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
      result    <= '0;
      dest_o    <= '0;
    end else begin
      valid_o   <= valid_i;
      illegal_o <= valid_i & illegal;
      if (valid_i) begin
        result <= illegal ? '0 : alu_res;
        dest_o <= dest_i;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: each step drives one op after a rising
// edge and checks the registered outputs 1 time unit after the next rising edge.
module tb_alu;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [5:0]  dest_i;
  logic        valid_o;
  logic [31:0] result;
  logic [5:0]  dest_o;
  logic        illegal_o;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .opcode    (opcode),
    .func3     (func3),
    .func7     (func7),
    .src1      (src1),
    .src2      (src2),
    .dest_i    (dest_i),
    .valid_o   (valid_o),
    .result    (result),
    .dest_o    (dest_o),
    .illegal_o (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] d);
    valid_i = v;
    opcode  = op;
    func3   = f3;
    func7   = f7;
    src1    = a;
    src2    = b;
    dest_i  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, OP, 3'b000, 7'h00, 32'd5, 32'd7, 6'd33);
    step();
    $display("reset with ADD 5+7 pending");
    chk("reset_valid", {31'b0, valid_o}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_dest", {26'b0, dest_o}, 32'd0);
    chk("reset_illegal", {31'b0, illegal_o}, 32'd0);
    rst = 1'b0;

    drive(1'b1, OP, 3'b000, 7'h00, 32'd5, 32'd7, 6'd33);
    step();
    $display("ADD 5+7 dest 33 -> %h/%0d", result, dest_o);
    chk("add_result", result, 32'd12);
    chk("add_dest", {26'b0, dest_o}, 32'd33);
    chk("add_valid", {31'b0, valid_o}, 32'd1);
    chk("add_illegal", {31'b0, illegal_o}, 32'd0);

    drive(1'b1, OP, 3'b000, 7'h20, 32'd3, 32'd5, 6'd1);
    step();
    $display("SUB 3-5 -> %h", result);
    chk("sub_result", result, 32'hFFFF_FFFE);

    drive(1'b1, OP_IMM, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1, 6'd2);
    step();
    $display("ADDI ffffffff+1 -> %h", result);
    chk("addi_wrap", result, 32'h0000_0000);

    drive(1'b1, OP_IMM, 3'b111, 7'h00, 32'h0000_F0F0, 32'h0000_00FF, 6'd3);
    step();
    $display("ANDI f0f0&0ff -> %h", result);
    chk("andi_result", result, 32'h0000_00F0);

    drive(1'b1, OP, 3'b100, 7'h00, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 6'd4);
    step();
    $display("XOR -> %h", result);
    chk("xor_result", result, 32'h5555_5555);

    drive(1'b1, OP, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 6'd5);
    step();
    $display("SRA 80000000>>>4 -> %h", result);
    chk("sra_result", result, 32'hF800_0000);

    // Upper bits of src2 must not affect the shift amount.
    drive(1'b1, OP, 3'b101, 7'h00, 32'h8000_0000, 32'h0000_0024, 6'd6);
    step();
    $display("SRL 80000000>>(0x24) -> %h", result);
    chk("srl_result", result, 32'h0800_0000);

    drive(1'b1, OP_IMM, 3'b101, 7'h20, 32'h8765_4321, 32'd0, 6'd7);
    step();
    $display("SRAI by 0 -> %h", result);
    chk("srai_zero", result, 32'h8765_4321);

    drive(1'b1, OP_IMM, 3'b001, 7'h00, 32'd1, 32'd31, 6'd8);
    step();
    $display("SLLI 1<<31 -> %h", result);
    chk("slli_result", result, 32'h8000_0000);

    drive(1'b1, OP, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 6'd9);
    step();
    $display("SLT -1<1 -> %h", result);
    chk("slt_result", result, 32'd1);

    drive(1'b1, OP_IMM, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 6'd9);
    step();
    $display("SLTIU ffffffff<1 -> %h", result);
    chk("sltiu_result", result, 32'd0);

    drive(1'b1, OP, 3'b110, 7'h00, 32'h0000_0F00, 32'h0000_000F, 6'd9);
    step();
    $display("OR -> %h", result);
    chk("or_result", result, 32'h0000_0F0F);

    drive(1'b1, OP, 3'b000, 7'h00, 32'd1, 32'd1, 6'd10);
    step();
    $display("pipe ADD 1+1 -> %h/%0d", result, dest_o);
    chk("pipe1_result", result, 32'd2);
    chk("pipe1_dest", {26'b0, dest_o}, 32'd10);
    drive(1'b1, OP, 3'b000, 7'h00, 32'd2, 32'd2, 6'd11);
    step();
    $display("pipe ADD 2+2 -> %h/%0d", result, dest_o);
    chk("pipe2_result", result, 32'd4);
    chk("pipe2_dest", {26'b0, dest_o}, 32'd11);
    chk("pipe2_valid", {31'b0, valid_o}, 32'd1);
    drive(1'b0, OP, 3'b000, 7'h00, 32'd9, 32'd9, 6'd12);
    step();
    $display("idle -> valid %0b result %h dest %0d", valid_o, result, dest_o);
    chk("idle_valid", {31'b0, valid_o}, 32'd0);
    chk("idle_result_hold", result, 32'd4);
    chk("idle_dest_hold", {26'b0, dest_o}, 32'd11);

    drive(1'b1, LW, 3'b010, 7'h55, 32'h0000_0100, 32'd8, 6'd13);
    step();
    $display("LW 100+8 -> %h", result);
    chk("lw_result", result, 32'h0000_0108);
    chk("lw_illegal", {31'b0, illegal_o}, 32'd0);

    drive(1'b1, SW, 3'b010, 7'h00, 32'h0000_2000, 32'hFFFF_FFFC, 6'd14);
    step();
    $display("SW 2000-4 -> %h/%0d", result, dest_o);
    chk("sw_result", result, 32'h0000_1FFC);
    chk("sw_dest", {26'b0, dest_o}, 32'd14);

    drive(1'b1, BR, 3'b000, 7'h00, 32'd5, 32'd5, 6'd15);
    step();
    $display("opcode 1100011 -> illegal %0b result %h", illegal_o, result);
    chk("illegal_flag", {31'b0, illegal_o}, 32'd1);
    chk("illegal_result", result, 32'd0);
    chk("illegal_valid", {31'b0, valid_o}, 32'd1);
    chk("illegal_dest", {26'b0, dest_o}, 32'd15);

    drive(1'b1, OP, 3'b000, 7'h01, 32'd5, 32'd5, 6'd16);
    step();
    $display("ADD bad func7 -> illegal %0b result %h", illegal_o, result);
    chk("badf7_illegal", {31'b0, illegal_o}, 32'd1);
    chk("badf7_result", result, 32'd0);

    drive(1'b0, BR, 3'b000, 7'h00, 32'd5, 32'd5, 6'd17);
    step();
    $display("idle with bad opcode -> illegal %0b", illegal_o);
    chk("idle_illegal_clear", {31'b0, illegal_o}, 32'd0);
    chk("idle_dest_hold2", {26'b0, dest_o}, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
